// File: rtl/truth_table_sweeper.sv
// Drives all 16 input vectors of a 4-input combinational block and captures its truth table.
// Optional golden-table compare (mismatch port) is built when TRUTH_TABLE_COMPARE_EN is defined.
module truth_table_sweeper #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter logic [15:0] EXPECTED    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  input  logic        y,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out
`ifdef TRUTH_TABLE_COMPARE_EN
  ,
  output logic        mismatch
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  hold_q, hold_d;
  logic [15:0] table_q, table_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 4'h0;
      hold_q  <= 8'h00;
      table_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      table_q <= table_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    table_d = table_q;
    busy    = 1'b0;
    done    = 1'b0;
    {a, b, c, d} = 4'h0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = 4'h0;
          hold_d  = 8'h00;
          table_d = 16'h0000;
        end
      end
      DRIVE: begin
        busy         = 1'b1;
        {a, b, c, d} = idx_q;
        // y is sampled on the last cycle of each vector's hold window
        if (hold_q == HOLD_LAST) begin
          hold_d         = 8'h00;
          table_d[idx_q] = y;
          if (idx_q == 4'hF) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign table_out = table_q;

`ifdef TRUTH_TABLE_COMPARE_EN
  logic mismatch_q, mismatch_d;

  // Compare against table_d so the final sampled bit is included at DONE entry
  always_comb begin
    mismatch_d = mismatch_q;
    if (state_q == IDLE && start) begin
      mismatch_d = 1'b0;
    end else if (state_q == DRIVE && state_d == DONE) begin
      mismatch_d = (table_d != EXPECTED);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_q <= 1'b0;
    end else begin
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: stimulus pushes expected tables, per-DUT monitors check vectors, latency and tables.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // DUT with HOLD_CYCLES=4, y selected by mode4
  logic        start4 = 1'b0;
  logic        a4, b4, c4, d4, y4, busy4, done4;
  logic [15:0] tab4;
  logic [1:0]  mode4 = 2'd0;   // 0: y=d, 1: parity, 2: y=0
`ifdef TRUTH_TABLE_COMPARE_EN
  logic        mm4;
`endif

  // DUT with HOLD_CYCLES=1, y=a&b
  logic        start1 = 1'b0;
  logic        a1, b1, c1, d1, y1, busy1, done1;
  logic [15:0] tab1;
`ifdef TRUTH_TABLE_COMPARE_EN
  logic        mm1;
`endif

  always_comb begin
    case (mode4)
      2'd0:    y4 = d4;
      2'd1:    y4 = a4 ^ b4 ^ c4 ^ d4;
      default: y4 = 1'b0;
    endcase
  end
  assign y1 = a1 & b1;

  truth_table_sweeper #(.HOLD_CYCLES(4), .EXPECTED(16'h6996)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .a(a4), .b(b4), .c(c4), .d(d4), .y(y4),
    .busy(busy4), .done(done4), .table_out(tab4)
`ifdef TRUTH_TABLE_COMPARE_EN
    , .mismatch(mm4)
`endif
  );

  truth_table_sweeper #(.HOLD_CYCLES(1), .EXPECTED(16'hF000)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .a(a1), .b(b1), .c(c1), .d(d1), .y(y1),
    .busy(busy1), .done(done1), .table_out(tab1)
`ifdef TRUTH_TABLE_COMPARE_EN
    , .mismatch(mm1)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] q4[$];
  logic [15:0] q1[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor for the HOLD_CYCLES=4 instance
  initial begin
    int run4;
    logic [15:0] e4;
    run4 = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run4 = 0;
      end else begin
        if (busy4) check("vec4", 32'({a4, b4, c4, d4}), 32'(run4 / 4));
        else       check("vec4_idle", 32'({a4, b4, c4, d4}), 32'd0);
        if (busy4 && done4) check("busy4_done4_overlap", 32'd1, 32'd0);
        if (done4) begin
          check("lat4", 32'(run4), 32'd64);
          if (q4.size() == 0) begin
            check("unexpected_done4", 32'd1, 32'd0);
          end else begin
            e4 = q4.pop_front();
            check("table4", 32'(tab4), 32'(e4));
          end
          run4 = 0;
        end
        if (busy4) run4++;
      end
    end
  end

  // Monitor for the HOLD_CYCLES=1 instance
  initial begin
    int run1;
    logic [15:0] e1;
    run1 = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run1 = 0;
      end else begin
        if (busy1) check("vec1", 32'({a1, b1, c1, d1}), 32'(run1));
        else       check("vec1_idle", 32'({a1, b1, c1, d1}), 32'd0);
        if (done1) begin
          check("lat1", 32'(run1), 32'd16);
          if (q1.size() == 0) begin
            check("unexpected_done1", 32'd1, 32'd0);
          end else begin
            e1 = q1.pop_front();
            check("table1", 32'(tab1), 32'(e1));
          end
          run1 = 0;
        end
        if (busy1) run1++;
      end
    end
  end

  task automatic wait_done4(input int max);
    int n;
    n = 0;
    while (done4 !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    check("done4_seen", 32'(done4), 32'd1);
  endtask

  task automatic wait_done1(input int max);
    int n;
    n = 0;
    while (done1 !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    check("done1_seen", 32'(done1), 32'd1);
  endtask

  task automatic pulse_start4();
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
  endtask

  initial begin
    // Reset state
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_done4", 32'(done4), 32'd0);
    check("rst_vec4", 32'({a4, b4, c4, d4}), 32'd0);
    check("rst_tab4", 32'(tab4), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_tab1", 32'(tab1), 32'd0);
`ifdef TRUTH_TABLE_COMPARE_EN
    check("rst_mm4", 32'(mm4), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // HOLD_CYCLES=1, y=a&b
    q1.push_back(16'hF000);
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    wait_done1(40);

    // HOLD_CYCLES=4, y=d; table holds afterwards in IDLE
    mode4 = 2'd0;
    q4.push_back(16'hAAAA);
    pulse_start4();
    wait_done4(100);
    repeat (3) @(posedge clk);
    #1 check("hold_tab4", 32'(tab4), 32'hAAAA);
    check("idle_busy4", 32'(busy4), 32'd0);

    // start held high across the whole sweep, parity function
    mode4 = 2'd1;
    q4.push_back(16'h6996);
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1;
    check("clr_tab4", 32'(tab4), 32'd0);
    check("busy4_on", 32'(busy4), 32'd1);
    wait_done4(100);
`ifdef TRUTH_TABLE_COMPARE_EN
    check("mm4_match", 32'(mm4), 32'd0);
`endif
    @(posedge clk); #1 start4 = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("no_resweep_busy4", 32'(busy4), 32'd0);
    check("no_resweep_tab4", 32'(tab4), 32'h6996);

    // Reset mid-sweep at index 7 aborts without done
    mode4 = 2'd0;
    pulse_start4();
    begin
      int n;
      n = 0;
      while ({a4, b4, c4, d4} != 4'd7 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("reach_idx7", 32'({a4, b4, c4, d4}), 32'd7);
    end
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("abort_busy4", 32'(busy4), 32'd0);
    check("abort_done4", 32'(done4), 32'd0);
    check("abort_vec4", 32'({a4, b4, c4, d4}), 32'd0);
    check("abort_tab4", 32'(tab4), 32'd0);
    @(posedge clk); #1;
    // start presented together with release: the first edge must accept it
    mode4 = 2'd1;
    q4.push_back(16'h6996);
    rst_n  = 1'b1;
    start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    check("first_edge_start4", 32'(busy4), 32'd1);
    wait_done4(100);

    // Forced y=0
    mode4 = 2'd2;
    q4.push_back(16'h0000);
    pulse_start4();
    wait_done4(100);
`ifdef TRUTH_TABLE_COMPARE_EN
    @(posedge clk); #1 check("mm4_forced_zero", 32'(mm4), 32'd1);
`endif

    repeat (4) @(posedge clk);
    #1;
    check("q4_drained", 32'(q4.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
